// File: rtl/rat_io_responder_if.sv
// CPU-side IN/OUT bus bundle for the port-mapped I/O responder.
// The CPU drives address, write data and the write strobe; the responder
// returns read data combinationally from the address.
interface rat_io_responder_if;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       io_strb;
   logic [7:0] in_port;

   modport master (
      output port_id,
      output out_port,
      output io_strb,
      input  in_port
   );

   modport slave (
      input  port_id,
      input  out_port,
      input  io_strb,
      output in_port
   );
endinterface

// File: rtl/rat_io_responder.sv
// Port-mapped I/O responder: LED register, synchronized switches,
// button-event FIFO with overflow flag, and a prescaled reloadable
// down-counter timer with a registered level interrupt.
module rat_io_responder #(
   parameter int PRESCALE   = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_BTN    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   rat_io_responder_if.slave   bus,
   input  logic [7:0]          switches,
   input  logic [NUM_BTN-1:0]  buttons,
   output logic [7:0]          leds,
   output logic                interrupt
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] FIFO_CAP   = CW'(FIFO_DEPTH);

   // Write map
   localparam logic [7:0] WR_LEDS   = 8'h40;
   localparam logic [7:0] WR_RELOAD = 8'h41;
   localparam logic [7:0] WR_CTRL   = 8'h42;
   localparam logic [7:0] WR_ACK    = 8'h43;
   localparam logic [7:0] WR_POP    = 8'h44;

   // Read map
   localparam logic [7:0] RD_SW     = 8'h20;
   localparam logic [7:0] RD_STATUS = 8'h21;
   localparam logic [7:0] RD_FIFO   = 8'h22;
   localparam logic [7:0] RD_COUNT  = 8'h23;
   localparam logic [7:0] RD_LEDS   = 8'h40;

   // Bus-visible registers
   logic [7:0]          leds_q, leds_d;
   logic [7:0]          reload_q, reload_d;
   logic                ten_q, ten_d;
   logic                ien_q, ien_d;

   // Timer state
   logic [7:0]          count_q, count_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic                pending_q, pending_d;
   logic                irq_q, irq_d;
   logic                tick;
   logic                pend_set;

   // Input synchronizers and edge detector
   logic [7:0]          sw_s1_q, sw_s2_q;
   logic [NUM_BTN-1:0]  btn_s1_q, btn_s2_q, btn_prev_q;
   logic [NUM_BTN-1:0]  rise;

   // Button-event FIFO
   logic [NUM_BTN-1:0]  mem_q [2**AW];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                fifo_empty, fifo_full;
   logic                push_req, do_push, do_pop;
   logic [3:0]          head4;

   // Write decode
   logic                wr_leds, wr_reload, wr_ctrl, wr_ack, wr_pop;
   logic [7:0]          rd_data;

   assign wr_leds   = bus.io_strb && (bus.port_id == WR_LEDS);
   assign wr_reload = bus.io_strb && (bus.port_id == WR_RELOAD);
   assign wr_ctrl   = bus.io_strb && (bus.port_id == WR_CTRL);
   assign wr_ack    = bus.io_strb && (bus.port_id == WR_ACK);
   assign wr_pop    = bus.io_strb && (bus.port_id == WR_POP);

   assign rise       = btn_s2_q & ~btn_prev_q;
   assign push_req   = |rise;
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == FIFO_CAP);

   // A pop on an empty FIFO does nothing; a push into a full FIFO only
   // lands if a pop frees a slot in the same cycle.
   assign do_pop  = wr_pop && !fifo_empty;
   assign do_push = push_req && (!fifo_full || do_pop);

   // Next state for the register file, timer and FIFO bookkeeping
   always_comb begin
      leds_d    = leds_q;
      reload_d  = reload_q;
      ten_d     = ten_q;
      ien_d     = ien_q;
      count_d   = count_q;
      presc_d   = presc_q;
      pending_d = pending_q;
      tick      = 1'b0;
      pend_set  = 1'b0;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;

      if (wr_leds)   leds_d   = bus.out_port;
      if (wr_reload) reload_d = bus.out_port;
      if (wr_ctrl) begin
         ten_d = bus.out_port[0];
         ien_d = bus.out_port[1];
      end

      // Prescaler runs only while enabled; its wrap is the timer tick.
      if (ten_q) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick    = 1'b1;
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end

      if (tick) begin
         if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
         end else begin
            count_d  = reload_q;
            pend_set = 1'b1;
         end
      end

      // Enabling the timer restarts it from the reload value. The timer
      // was idle, so this never collides with a tick.
      if (wr_ctrl && bus.out_port[0] && !ten_q) begin
         count_d = reload_q;
         presc_d = '0;
      end

      // A new expiry in the same cycle as an ack keeps the request alive.
      if (wr_ack)   pending_d = 1'b0;
      if (pend_set) pending_d = 1'b1;

      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase

      if (wr_pop) ovf_d = 1'b0;
      if (push_req && fifo_full && !do_pop) ovf_d = 1'b1;
   end

   assign irq_d = pending_q & ien_q;

   // Control and data registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         leds_q     <= '0;
         reload_q   <= '0;
         ten_q      <= 1'b0;
         ien_q      <= 1'b0;
         count_q    <= '0;
         presc_q    <= '0;
         pending_q  <= 1'b0;
         irq_q      <= 1'b0;
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         btn_s1_q   <= '0;
         btn_s2_q   <= '0;
         btn_prev_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         leds_q     <= leds_d;
         reload_q   <= reload_d;
         ten_q      <= ten_d;
         ien_q      <= ien_d;
         count_q    <= count_d;
         presc_q    <= presc_d;
         pending_q  <= pending_d;
         irq_q      <= irq_d;
         sw_s1_q    <= switches;
         sw_s2_q    <= sw_s1_q;
         btn_s1_q   <= buttons;
         btn_s2_q   <= btn_s1_q;
         btn_prev_q <= btn_s2_q;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   // FIFO storage; contents are only meaningful below the occupancy count
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= rise;
   end

   // Head entry widened to a 4-bit one-hot field, zero when empty
   always_comb begin
      head4 = '0;
      if (!fifo_empty) head4[NUM_BTN-1:0] = mem_q[rd_ptr_q];
   end

   // Combinational read decode; unmapped addresses read as zero
   always_comb begin
      rd_data = 8'h00;
      case (bus.port_id)
         RD_SW:     rd_data = sw_s2_q;
         RD_STATUS: rd_data = {ovf_q, 3'b000, fifo_full, fifo_empty, pending_q, ten_q};
         RD_FIFO:   rd_data = {4'b0000, head4};
         RD_COUNT:  rd_data = count_q;
         RD_LEDS:   rd_data = leds_q;
         default:   rd_data = 8'h00;
      endcase
   end

   assign bus.in_port = rd_data;
   assign leds        = leds_q;
   assign interrupt   = irq_q;

endmodule

// File: tb/tb_rat_io_responder.sv
// Directed bench for rat_io_responder: LED writes, timer interrupt and
// gating, button FIFO order/overflow, switch sync and async reset.
module tb_rat_io_responder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] switches = 8'h00;
   logic [3:0] buttons = 4'h0;
   logic [7:0] leds;
   logic       interrupt;
   int         errors = 0;
   int         checks = 0;

   rat_io_responder_if bus_if();

   rat_io_responder #(.PRESCALE(4), .FIFO_DEPTH(4), .NUM_BTN(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_if),
      .switches  (switches),
      .buttons   (buttons),
      .leds      (leds),
      .interrupt (interrupt)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%02h expected=%02h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [7:0] p, input logic [7:0] d);
      bus_if.port_id  = p;
      bus_if.out_port = d;
      bus_if.io_strb  = 1'b1;
      step(1);
      bus_if.io_strb  = 1'b0;
      bus_if.port_id  = 8'h00;
   endtask

   task automatic rd(input string tag, input logic [7:0] p, input logic [7:0] exp);
      bus_if.port_id = p;
      #1;
      chk(tag, bus_if.in_port, exp);
   endtask

   task automatic pulse(input int b);
      buttons[b] = 1'b1;
      step(2);
      buttons[b] = 1'b0;
      step(2);
   endtask

   initial begin
      bus_if.port_id  = 8'h00;
      bus_if.out_port = 8'h00;
      bus_if.io_strb  = 1'b0;
      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(1);

      // Reset state
      chk("rst_leds", leds, 8'h00);
      chk("rst_irq", {7'd0, interrupt}, 8'h00);
      rd("rst_status", 8'h21, 8'h04);
      rd("rst_sw", 8'h20, 8'h00);
      rd("rst_fifo", 8'h22, 8'h00);
      rd("rst_count", 8'h23, 8'h00);
      rd("unmapped_rd", 8'h30, 8'h00);

      // LED register
      wr(8'h40, 8'h3C);
      chk("led_write", leds, 8'h3C);
      rd("led_readback", 8'h40, 8'h3C);
      wr(8'h55, 8'h99);
      chk("led_unmapped_wr", leds, 8'h3C);
      rd("unmapped_55", 8'h55, 8'h00);
      rd("reload_not_readable", 8'h41, 8'h00);

      // Timer: reload 2, enable + IEN; irq 13 edges after the ctrl edge
      wr(8'h41, 8'h02);
      wr(8'h42, 8'h03);
      chk("tmr_irq_e1", {7'd0, interrupt}, 8'h00);
      rd("tmr_cnt_load", 8'h23, 8'h02);
      step(4);
      rd("tmr_cnt_tick1", 8'h23, 8'h01);
      step(4);
      rd("tmr_cnt_tick2", 8'h23, 8'h00);
      step(4);
      chk("tmr_irq_e12", {7'd0, interrupt}, 8'h00);
      rd("tmr_status_pend", 8'h21, 8'h07);
      rd("tmr_cnt_reload", 8'h23, 8'h02);
      step(1);
      chk("tmr_irq_e13", {7'd0, interrupt}, 8'h01);
      wr(8'h43, 8'h00);
      chk("ack_irq_still", {7'd0, interrupt}, 8'h01);
      step(1);
      chk("ack_irq_low", {7'd0, interrupt}, 8'h00);
      rd("ack_status", 8'h21, 8'h05);
      wr(8'h42, 8'h00);

      // Interrupt gating: pending without IEN, then enable IEN
      wr(8'h42, 8'h01);
      step(12);
      rd("gate_status", 8'h21, 8'h07);
      chk("gate_irq_off", {7'd0, interrupt}, 8'h00);
      step(1);
      chk("gate_irq_off2", {7'd0, interrupt}, 8'h00);
      wr(8'h42, 8'h03);
      chk("gate_irq_wr", {7'd0, interrupt}, 8'h00);
      step(1);
      chk("gate_irq_on", {7'd0, interrupt}, 8'h01);
      wr(8'h42, 8'h00);
      wr(8'h43, 8'h00);
      chk("gate_irq_clr", {7'd0, interrupt}, 8'h00);
      rd("gate_status_clr", 8'h21, 8'h04);

      // Button FIFO: five events into four slots
      pulse(0);
      pulse(2);
      pulse(1);
      pulse(3);
      pulse(0);
      step(4);
      rd("fifo_full_ovf", 8'h21, 8'h88);
      rd("fifo_head0", 8'h22, 8'h01);
      wr(8'h44, 8'h00);
      rd("fifo_ovf_clr", 8'h21, 8'h00);
      rd("fifo_head1", 8'h22, 8'h04);
      wr(8'h44, 8'h00);
      rd("fifo_head2", 8'h22, 8'h02);
      wr(8'h44, 8'h00);
      rd("fifo_head3", 8'h22, 8'h08);
      wr(8'h44, 8'h00);
      rd("fifo_empty_head", 8'h22, 8'h00);
      rd("fifo_empty_status", 8'h21, 8'h04);
      wr(8'h44, 8'h00);
      rd("fifo_pop_empty", 8'h21, 8'h04);

      // Switch synchronizer latency
      switches = 8'h81;
      rd("sw_old0", 8'h20, 8'h00);
      step(1);
      rd("sw_old1", 8'h20, 8'h00);
      step(1);
      rd("sw_new", 8'h20, 8'h81);
      step(1);
      rd("sw_hold", 8'h20, 8'h81);

      // Asynchronous reset mid-run
      wr(8'h40, 8'hA5);
      buttons[1] = 1'b1;
      step(2);
      buttons[1] = 1'b0;
      step(3);
      rd("pre_rst_status", 8'h21, 8'h00);
      wr(8'h41, 8'h00);
      wr(8'h42, 8'h03);
      step(6);
      chk("pre_rst_irq", {7'd0, interrupt}, 8'h01);
      chk("pre_rst_leds", leds, 8'hA5);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_leds", leds, 8'h00);
      chk("async_rst_irq", {7'd0, interrupt}, 8'h00);
      rd("async_rst_status", 8'h21, 8'h04);
      step(1);
      rst_n = 1'b1;
      step(2);
      rd("post_rst_status", 8'h21, 8'h04);
      rd("post_rst_count", 8'h23, 8'h00);
      chk("post_rst_irq", {7'd0, interrupt}, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
